shader_scan_scheduler: RTL and testbench
========================================

# shader_scan_scheduler

Parametrised scan and shader scheduler for the tiny shader display path. It generates VGA-style horizontal and vertical timing and decides which shader block executes on each cycle, so every displayed pixel block has been computed exactly NUM_INSTR cycles ahead. It also captures and blanks the shader colour, and maintains a frame-time value with selectable bounce or wrap behaviour. It sits between the shader memory/execute units and the video output pins, and supersedes the fixed 640x480, 12-instruction scheduling logic.

## Interface
- WIDTH, 640: visible pixels per line; must be a multiple of NUM_INSTR.
- HEIGHT, 480: visible lines.
- HFRONT / HSYNC / HBACK, 16 / 96 / 48: horizontal porches and sync width, in cycles.
- VFRONT / VSYNC / VBACK, 10 / 2 / 33: vertical porches and sync width, in lines.
- SYNC_ACTIVE_LOW, 1: 1 means hsync_o and vsync_o are low while asserted.
- NUM_INSTR, 10: cycles per shader block, and block size in both x and y. Must be ≥2 and ≤ HFRONT+HSYNC+HBACK.
- TIME_W, 8: width of the frame-time value.
- COLOR_W, 6: colour width.
- clk_i  in  1  pixel clock.
- rst_i  in  1  reset; asynchronous, active-high.
- enable_i  in  1  when 0, all state holds.
- time_mode_i  in  1  0 selects bounce, 1 selects wrap.
- time_step_i  in  4  frame-time increment per frame.
- rgb_i  in  COLOR_W  shader result.
- hsync_o, vsync_o  out  1  sync outputs.
- next_line_o  out  1  one-cycle pulse on the last cycle of each line.
- next_frame_o  out  1  one-cycle pulse on the last cycle of each frame.
- execute_o  out  1  shader executes this cycle.
- subpos_o  out  clog2(NUM_INSTR)  instruction index within the current block.
- x_pos_o  out  clog2(WIDTH/NUM_INSTR)  target block column.
- y_pos_o  out  clog2(HEIGHT/NUM_INSTR)  target block row.
- capture_o  out  1  rgb_i is captured at the end of this cycle.
- cur_time_o  out  TIME_W  frame time.
- rrggbb_o  out  COLOR_W  displayed colour.

## Operation
- Horizontal counter h runs 0..HTOTAL-1; vertical counter v runs 0..VTOTAL-1. Both are unsigned. h=0 is the first visible pixel.
- v advances when next_line_o is high. next_line_o = enable_i && h==HTOTAL-1. next_frame_o = next_line_o && v==VTOTAL-1.
- hsync is asserted for h in [WIDTH+HFRONT, WIDTH+HFRONT+HSYNC-1]. vsync is asserted for v in [HEIGHT+VFRONT, HEIGHT+VFRONT+VSYNC-1]. Both are driven at the level set by SYNC_ACTIVE_LOW.
- Target position: t = h+NUM_INSTR. If t ≥ HTOTAL, t wraps to t-HTOTAL and the target line is v+1 (modulo VTOTAL); otherwise the target line is v.
- execute_o = enable_i && t<WIDTH && target line<HEIGHT.
- Block and row positions while execute_o is high:
  - subpos_o = t mod NUM_INSTR.
  - x_pos_o = t / NUM_INSTR.
  - y_pos_o = target line / NUM_INSTR. Implemented with a row sub-counter, not a divider.
- capture_o = execute_o && subpos_o==NUM_INSTR-1. On capture, a COLOR_W register takes rgb_i.
- rrggbb_o = capture register when h<WIDTH and v<HEIGHT; otherwise 0.
- Frame time advances on next_frame_o only. Saturation uses TIME_MAX = 2^TIME_W-1.
  - Wrap mode: time += step, modulo 2^TIME_W.
  - Bounce mode, direction up: if time+step ≥ TIME_MAX, time becomes TIME_MAX and direction becomes down; otherwise time += step.
  - Bounce mode, direction down: if time ≤ step, time becomes 0 and direction becomes up; otherwise time -= step.
  - time_step_i==0 leaves time and direction unchanged.
  - time_mode_i is sampled only at next_frame_o. Wrap mode forces direction to up.
- Parameter violations (WIDTH not a multiple of NUM_INSTR, insufficient blanking) are caught by elaboration-time assertions.

## Timing
- Reset values: h=v=0, hsync/vsync inactive, next_line_o=next_frame_o=0, capture register=0 so rrggbb_o=0, cur_time_o=0, direction up, subpos_o=0.
- In the first frame after reset, block 0 of line 0 displays 0 because it had no lead time.
- Colour latency: block k executes cycles h = kN-N .. kN-1, wrapping into the previous line for k=0. It is captured at h=kN-1 and shown on rrggbb_o for h = kN .. kN+N-1.
- Sync, pulse, execute, position and capture outputs are combinational decodes of registered counters. rrggbb_o and cur_time_o come directly from registers.
- Reset is asynchronous and may occur mid-line. All state returns immediately to reset values; no partial block completes.
- enable_i low freezes the counters, the capture register and the time value. Pulse, execute and capture outputs are forced 0 while frozen.

## Structure
- shader_pkg holds:
  - the time_mode_t enum (BOUNCE, WRAP);
  - the default 640x480 timing localparams;
  - the NUM_INSTR default.
- One sub-module, scan_axis_counter, is instantiated twice (horizontal and vertical). It provides the counter, the wrap pulse, and the sync and visible decodes, parametrised by RESOLUTION, FRONT, SYNC, BACK and an increment enable.

## Test plan
- Reset, then run one full frame with defaults: hsync low for 96 cycles starting at h=656; vsync low for 2 lines starting at line 490; exactly 800*525 cycles between next_frame_o pulses.
- rgb_i = x_pos_o ^ y_pos_o: on every visible pixel of frame 2, rrggbb_o equals (h/10)^(v/10); blanking shows 0.
- Line-wrap lead: at h=790 of line 9, execute_o=1, x_pos_o=0, y_pos_o=1, subpos_o=0. At h=790 of line 479, execute_o=0.
- Bounce, step 7, from 0: time reaches 252, then saturates at 255, then goes to 248. Wrap, step 7, from 252: time becomes 3.
- Pause enable_i for 50 cycles mid-line: h, v and the outputs hold; the sequence resumes identically to an unpaused reference shifted by 50 cycles.
- Assert rst_i at h=300, v=200 mid-block: all outputs take their reset values in the same cycle; after release, the first line starts at h=0.

Source files
------------

// File: rtl/shader_pkg.sv
// rtl/shader_pkg.sv - shared types, default 640x480 timing and width helper for the shader scan path
package shader_pkg;

  typedef enum logic {BOUNCE = 1'b0, WRAP = 1'b1} time_mode_t;
  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} time_dir_t;

  localparam int DEF_WIDTH     = 640;
  localparam int DEF_HEIGHT    = 480;
  localparam int DEF_HFRONT    = 16;
  localparam int DEF_HSYNC     = 96;
  localparam int DEF_HBACK     = 48;
  localparam int DEF_VFRONT    = 10;
  localparam int DEF_VSYNC     = 2;
  localparam int DEF_VBACK     = 33;
  localparam int DEF_NUM_INSTR = 10;

  // Bit width for values 0..n-1, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/scan_axis_counter.sv
// rtl/scan_axis_counter.sv - one scan axis: position counter, wrap pulse, sync and visible decodes
module scan_axis_counter #(
  parameter int RESOLUTION = 640,
  parameter int FRONT      = 16,
  parameter int SYNC       = 96,
  parameter int BACK       = 48,
  parameter int CW         = $clog2(RESOLUTION + FRONT + SYNC + BACK)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          inc_i,
  output logic [CW-1:0] cnt_o,
  output logic          wrap_o,
  output logic          sync_o,
  output logic          visible_o
);

  localparam int TOTAL = RESOLUTION + FRONT + SYNC + BACK;

  assign wrap_o    = inc_i && (cnt_o == CW'(TOTAL - 1));
  assign sync_o    = (cnt_o >= CW'(RESOLUTION + FRONT)) && (cnt_o < CW'(RESOLUTION + FRONT + SYNC));
  assign visible_o = cnt_o < CW'(RESOLUTION);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_o <= '0;
    end else if (wrap_o) begin
      cnt_o <= '0;
    end else if (inc_i) begin
      cnt_o <= cnt_o + CW'(1);
    end
  end

endmodule

// File: rtl/shader_scan_scheduler.sv
// rtl/shader_scan_scheduler.sv - scan timing, shader block scheduling N cycles ahead, colour capture and frame time
module shader_scan_scheduler
  import shader_pkg::*;
#(
  parameter int WIDTH           = DEF_WIDTH,
  parameter int HEIGHT          = DEF_HEIGHT,
  parameter int HFRONT          = DEF_HFRONT,
  parameter int HSYNC           = DEF_HSYNC,
  parameter int HBACK           = DEF_HBACK,
  parameter int VFRONT          = DEF_VFRONT,
  parameter int VSYNC           = DEF_VSYNC,
  parameter int VBACK           = DEF_VBACK,
  parameter bit SYNC_ACTIVE_LOW = 1'b1,
  parameter int NUM_INSTR       = DEF_NUM_INSTR,
  parameter int TIME_W          = 8,
  parameter int COLOR_W         = 6,
  localparam int SW             = clog2_min1(NUM_INSTR),
  localparam int XW             = clog2_min1(WIDTH / NUM_INSTR),
  localparam int YW             = clog2_min1(HEIGHT / NUM_INSTR)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               enable_i,
  input  logic               time_mode_i,
  input  logic [3:0]         time_step_i,
  input  logic [COLOR_W-1:0] rgb_i,
  output logic               hsync_o,
  output logic               vsync_o,
  output logic               next_line_o,
  output logic               next_frame_o,
  output logic               execute_o,
  output logic [SW-1:0]      subpos_o,
  output logic [XW-1:0]      x_pos_o,
  output logic [YW-1:0]      y_pos_o,
  output logic               capture_o,
  output logic [TIME_W-1:0]  cur_time_o,
  output logic [COLOR_W-1:0] rrggbb_o
);

  localparam int HTOTAL = WIDTH + HFRONT + HSYNC + HBACK;
  localparam int VTOTAL = HEIGHT + VFRONT + VSYNC + VBACK;
  localparam int HW     = $clog2(HTOTAL);
  localparam int VW     = $clog2(VTOTAL);
  localparam logic [TIME_W-1:0] TIME_MAX = '1;

  if (WIDTH % NUM_INSTR != 0) begin : g_bad_width
    $error("WIDTH must be a multiple of NUM_INSTR");
  end
  if (NUM_INSTR < 2 || NUM_INSTR > HFRONT + HSYNC + HBACK) begin : g_bad_blank
    $error("NUM_INSTR must be at least 2 and fit in the horizontal blanking");
  end

  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic h_sync, v_sync, h_vis, v_vis;

  scan_axis_counter #(
    .RESOLUTION(WIDTH), .FRONT(HFRONT), .SYNC(HSYNC), .BACK(HBACK), .CW(HW)
  ) u_h_axis (
    .clk_i(clk_i), .rst_i(rst_i), .inc_i(enable_i),
    .cnt_o(h), .wrap_o(next_line_o), .sync_o(h_sync), .visible_o(h_vis)
  );

  scan_axis_counter #(
    .RESOLUTION(HEIGHT), .FRONT(VFRONT), .SYNC(VSYNC), .BACK(VBACK), .CW(VW)
  ) u_v_axis (
    .clk_i(clk_i), .rst_i(rst_i), .inc_i(next_line_o),
    .cnt_o(v), .wrap_o(next_frame_o), .sync_o(v_sync), .visible_o(v_vis)
  );

  assign hsync_o = SYNC_ACTIVE_LOW ? ~h_sync : h_sync;
  assign vsync_o = SYNC_ACTIVE_LOW ? ~v_sync : v_sync;

  // Target t = h + NUM_INSTR; lead_wrap means t has spilled into the next line.
  logic lead_wrap, lead_step, t_vis, tline_vis;
  assign lead_wrap = h >= HW'(HTOTAL - NUM_INSTR);
  assign lead_step = enable_i && (h == HW'(HTOTAL - NUM_INSTR - 1));
  assign t_vis     = lead_wrap || (h < HW'(WIDTH - NUM_INSTR));
  assign tline_vis = lead_wrap ? ((v < VW'(HEIGHT - 1)) || (v == VW'(VTOTAL - 1))) : v_vis;
  assign execute_o = enable_i && t_vis && tline_vis;

  // Block/row counters track t and the target line; they only need to be right while executing.
  logic [SW-1:0] sub_q, row_sub_q;
  logic [XW-1:0] xblk_q;
  logic [YW-1:0] row_blk_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sub_q     <= '0;
      xblk_q    <= XW'(1);
      row_sub_q <= '0;
      row_blk_q <= '0;
    end else if (enable_i) begin
      if (lead_step) begin
        sub_q  <= '0;
        xblk_q <= '0;
        if (v == VW'(VTOTAL - 1)) begin
          row_sub_q <= '0;
          row_blk_q <= '0;
        end else if (row_sub_q == SW'(NUM_INSTR - 1)) begin
          row_sub_q <= '0;
          row_blk_q <= row_blk_q + YW'(1);
        end else begin
          row_sub_q <= row_sub_q + SW'(1);
        end
      end else if (sub_q == SW'(NUM_INSTR - 1)) begin
        sub_q  <= '0;
        xblk_q <= xblk_q + XW'(1);
      end else begin
        sub_q <= sub_q + SW'(1);
      end
    end
  end

  assign subpos_o  = sub_q;
  assign x_pos_o   = xblk_q;
  assign y_pos_o   = row_blk_q;
  assign capture_o = execute_o && (sub_q == SW'(NUM_INSTR - 1));

  // Colour output is registered, so blanking is decided for the position the counters move to.
  logic [COLOR_W-1:0] cap_q, cap_d, rgb_q;
  logic h_vis_next, v_vis_next;
  assign cap_d      = capture_o ? rgb_i : cap_q;
  assign h_vis_next = (h < HW'(WIDTH - 1)) || next_line_o;
  assign v_vis_next = next_line_o ? ((v < VW'(HEIGHT - 1)) || next_frame_o) : v_vis;

  time_mode_t mode;
  time_dir_t  dir_q, dir_d;
  logic [TIME_W-1:0] time_q, time_d;
  logic [TIME_W:0]   step_x, sum_x;

  assign mode   = time_mode_t'(time_mode_i);
  assign step_x = (TIME_W + 1)'(time_step_i);
  assign sum_x  = {1'b0, time_q} + step_x;

  always_comb begin
    time_d = time_q;
    dir_d  = dir_q;
    if (next_frame_o && (time_step_i != 4'd0)) begin
      if (mode == WRAP) begin
        time_d = sum_x[TIME_W-1:0];
        dir_d  = DIR_UP;
      end else if (dir_q == DIR_UP) begin
        if (sum_x >= {1'b0, TIME_MAX}) begin
          time_d = TIME_MAX;
          dir_d  = DIR_DOWN;
        end else begin
          time_d = sum_x[TIME_W-1:0];
        end
      end else if ({1'b0, time_q} <= step_x) begin
        time_d = '0;
        dir_d  = DIR_UP;
      end else begin
        time_d = time_q - step_x[TIME_W-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cap_q  <= '0;
      rgb_q  <= '0;
      time_q <= '0;
      dir_q  <= DIR_UP;
    end else if (enable_i) begin
      cap_q  <= cap_d;
      rgb_q  <= (h_vis_next && v_vis_next) ? cap_d : '0;
      time_q <= time_d;
      dir_q  <= dir_d;
    end
  end

  assign rrggbb_o   = rgb_q;
  assign cur_time_o = time_q;

endmodule

// File: tb/tb_shader_scan_scheduler.sv
// tb/tb_shader_scan_scheduler.sv - directed bench for shader_scan_scheduler on a reduced 24x16 raster
module tb_shader_scan_scheduler;

  localparam int W = 16, H = 12, HF = 2, HS = 3, HB = 3;
  localparam int VF = 1, VS = 2, VB = 1, N = 4;
  localparam int HT = W + HF + HS + HB;
  localparam int VT = H + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       enable_i = 1'b1;
  logic       time_mode_i = 1'b0;
  logic [3:0] time_step_i = 4'd0;
  logic [5:0] rgb_i;
  logic       hsync_o, vsync_o, next_line_o, next_frame_o, execute_o, capture_o;
  logic [1:0] subpos_o, x_pos_o, y_pos_o;
  logic [7:0] cur_time_o;
  logic [5:0] rrggbb_o;

  int n_cmp = 0;
  int n_bad = 0;
  int mh = 0;
  int mv = 0;

  shader_scan_scheduler #(
    .WIDTH(W), .HEIGHT(H), .HFRONT(HF), .HSYNC(HS), .HBACK(HB),
    .VFRONT(VF), .VSYNC(VS), .VBACK(VB), .SYNC_ACTIVE_LOW(1'b1),
    .NUM_INSTR(N), .TIME_W(8), .COLOR_W(6)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .time_mode_i(time_mode_i),
    .time_step_i(time_step_i), .rgb_i(rgb_i), .hsync_o(hsync_o), .vsync_o(vsync_o),
    .next_line_o(next_line_o), .next_frame_o(next_frame_o), .execute_o(execute_o),
    .subpos_o(subpos_o), .x_pos_o(x_pos_o), .y_pos_o(y_pos_o), .capture_o(capture_o),
    .cur_time_o(cur_time_o), .rrggbb_o(rrggbb_o)
  );

  // Shader stand-in: colour encodes the block it was computed for.
  assign rgb_i = {2'b00, y_pos_o, x_pos_o};

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    if (enable_i && !rst_i) begin
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh++;
      end
    end
  endtask

  task automatic check_all();
    int t, tl;
    logic ex;
    t  = mh + N;
    tl = mv;
    if (t >= HT) begin
      t  = t - HT;
      tl = (mv + 1) % VT;
    end
    ex = enable_i && (t < W) && (tl < H);
    chk("hsync", hsync_o, !(mh >= W + HF && mh < W + HF + HS));
    chk("vsync", vsync_o, !(mv >= H + VF && mv < H + VF + VS));
    chk("next_line", next_line_o, enable_i && mh == HT - 1);
    chk("next_frame", next_frame_o, enable_i && mh == HT - 1 && mv == VT - 1);
    chk("execute", execute_o, ex);
    if (ex) begin
      chk("subpos", subpos_o, t % N);
      chk("x_pos", x_pos_o, t / N);
      chk("y_pos", y_pos_o, tl / N);
    end
    chk("capture", capture_o, ex && (t % N == N - 1));
    chk("rrggbb", rrggbb_o, (mh < W && mv < H) ? ((mv / N) * 4 + mh / N) : 0);
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check_all();
    end
  endtask

  task automatic run_until(input int th, input int tv, input int bound, input string tag, output int used);
    used = 0;
    while (!(mh == th && mv == tv) && used < bound) begin
      tick();
      check_all();
      used++;
    end
    if (!(mh == th && mv == tv)) chk(tag, used, bound + 1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_hsync"}, hsync_o, 1);
    chk({tag, "_vsync"}, vsync_o, 1);
    chk({tag, "_next_line"}, next_line_o, 0);
    chk({tag, "_next_frame"}, next_frame_o, 0);
    chk({tag, "_rrggbb"}, rrggbb_o, 0);
    chk({tag, "_time"}, cur_time_o, 0);
    chk({tag, "_subpos"}, subpos_o, 0);
  endtask

  initial begin
    int hs_cnt, hs_first, vs_lines, vs_first, nf_cnt, nf_last, nf_gap, used;

    // Reset state
    rst_i = 1'b1;
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    check_reset_values("reset");
    rst_i = 1'b0;
    mh = 0;
    mv = 0;
    check_all();

    // Two full frames: timing decodes, pulse spacing and colour pipeline
    hs_cnt = 0; hs_first = -1; vs_lines = 0; vs_first = -1;
    nf_cnt = 0; nf_last = -1; nf_gap = 0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      if (k < HT && !hsync_o) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = mh;
      end
      if (k < FRAME && mh == 0 && !vsync_o) begin
        vs_lines++;
        if (vs_first < 0) vs_first = mv;
      end
      if (next_frame_o) begin
        if (nf_last >= 0) nf_gap = k - nf_last;
        nf_last = k;
        nf_cnt++;
      end
      tick();
      check_all();
    end
    chk("hsync_len", hs_cnt, HS);
    chk("hsync_start", hs_first, W + HF);
    chk("vsync_lines", vs_lines, VS);
    chk("vsync_start", vs_first, H + VF);
    chk("frame_pulses", nf_cnt, 2);
    chk("frame_period", nf_gap, FRAME);

    // Freeze mid-line for 50 cycles, then resume
    run_cycles(2 * HT + 7);
    enable_i = 1'b0;
    run_cycles(50);
    chk("pause_rrggbb_hold", rrggbb_o, (2 / N) * 4 + 7 / N);
    enable_i = 1'b1;
    run_cycles(FRAME + 16);

    // Asynchronous reset in the middle of a block
    run_until(10, 5, FRAME + HT, "reach_mid_block", used);
    chk("pre_reset_subpos", subpos_o, (10 + N) % N);
    rst_i = 1'b1;
    #1;
    check_reset_values("async_reset");
    @(posedge clk_i);
    #1;
    check_reset_values("reset_held");
    rst_i = 1'b0;
    mh = 0;
    mv = 0;
    check_all();
    run_until(HT - 1, 0, 2 * HT, "first_line_end", used);
    chk("first_line_len", used, HT - 1);
    chk("first_line_pulse", next_line_o, 1);

    // Lead into the next line and the last visible row boundary
    run_until(HT - N, N - 1, FRAME, "reach_lead_wrap", used);
    chk("lead_execute", execute_o, 1);
    chk("lead_x_pos", x_pos_o, 0);
    chk("lead_y_pos", y_pos_o, 1);
    chk("lead_subpos", subpos_o, 0);
    run_until(HT - N, H - 1, FRAME, "reach_last_row", used);
    chk("last_row_execute", execute_o, 0);

    // Frame time: bounce up to saturation, turn around, wrap, then bounce restarting upward
    rst_i = 1'b1;
    tick();
    time_mode_i = 1'b0;
    time_step_i = 4'd7;
    rst_i = 1'b0;
    mh = 0;
    mv = 0;
    chk("time_start", cur_time_o, 0);
    run_cycles(36 * FRAME);
    chk("bounce_252", cur_time_o, 252);
    run_cycles(FRAME);
    chk("bounce_sat_255", cur_time_o, 255);
    run_cycles(FRAME);
    chk("bounce_down_248", cur_time_o, 248);
    time_mode_i = 1'b1;
    run_cycles(FRAME);
    chk("wrap_255", cur_time_o, 255);
    run_cycles(FRAME);
    chk("wrap_roll_6", cur_time_o, 6);
    time_mode_i = 1'b0;
    run_cycles(FRAME);
    chk("bounce_after_wrap_13", cur_time_o, 13);
    time_step_i = 4'd0;
    run_cycles(FRAME);
    chk("step0_hold_13", cur_time_o, 13);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
